// File: rtl/pick_job_scheduler.sv
// pick_job_scheduler: queues manual/camera pick jobs and hands them one at a time
// to the motion sequencer, supervising its acknowledge and completion.
module pick_job_scheduler #(
    parameter int DEPTH    = 4,
    parameter int ACK_MAX  = 50_000,
    parameter int DONE_MAX = 1_000_000_000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   key_valid,
    input  logic [34:0]            key_job,
    input  logic                   cam_valid,
    input  logic [34:0]            cam_job,
    input  logic                   sched_en,
    input  logic                   flush,
    output logic                   job_start,
    output logic [34:0]            job_data,
    input  logic                   job_finish,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   req_drop,
    output logic                   ack_timeout,
    output logic                   done_timeout,
    output logic [7:0]             jobs_done
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = DONE_MAX > ACK_MAX ? DONE_MAX : ACK_MAX;
    localparam int CW   = $clog2(TMAX) > 4 ? $clog2(TMAX) : 4;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, lim;
    logic [34:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic [34:0]   job_q;
    logic          start_q, drop_q, ack_q, ack_d, dto_q, dto_d;
    logic [7:0]    done_q, done_d;
    logic          req, pop, push;

    assign req  = key_valid | cam_valid;
    assign pop  = state_q == IDLE && sched_en && job_finish && count_q != '0;
    // a full queue still accepts a request in the same cycle it pops the head
    assign push = req && !flush && (count_q != (AW+1)'(DEPTH) || pop);

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dto_d   = dto_q;
        done_d  = done_q;
        case (state_q)
            IDLE:      state_d = pop ? ISSUE : IDLE;
            ISSUE: begin
                state_d = WAIT_BUSY;
                dto_d   = 1'b0;
            end
            WAIT_BUSY: begin
                ack_d   = job_finish && cnt_q == lim;
                state_d = !job_finish ? WAIT_DONE : ack_d ? GAP : WAIT_BUSY;
            end
            WAIT_DONE: begin
                state_d = job_finish ? GAP : WAIT_DONE;
                done_d  = job_finish ? done_q + 8'd1 : done_q;
                dto_d   = dto_q || (!job_finish && cnt_q == lim);
            end
            GAP:       state_d = cnt_q == lim ? IDLE : GAP;
            default:   state_d = IDLE;
        endcase
        lim   = state_q == WAIT_BUSY ? CW'(ACK_MAX - 1) :
                state_q == WAIT_DONE ? CW'(DONE_MAX - 1) : CW'(15);
        cnt_d = state_d != state_q ? '0 : cnt_q == lim ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge sys_clk)
        if (push) mem_q[wr_q] <= key_valid ? key_job : cam_job;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            job_q   <= '0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
            ack_q   <= 1'b0;
            dto_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= flush ? '0 : wr_q + AW'(push);
            rd_q    <= flush ? '0 : rd_q + AW'(pop);
            count_q <= flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
            job_q   <= pop ? mem_q[rd_q] : job_q;
            start_q <= state_q == ISSUE;
            drop_q  <= (key_valid && cam_valid) || (req && !push);
            ack_q   <= ack_d;
            dto_q   <= dto_d;
            done_q  <= done_d;
        end
    end

    assign job_start    = start_q;
    assign job_data     = job_q;
    assign busy         = state_q != IDLE;
    assign fifo_count   = count_q;
    assign req_drop     = drop_q;
    assign ack_timeout  = ack_q;
    assign done_timeout = dto_q;
    assign jobs_done    = done_q;
endmodule

// File: tb/tb_pick_job_scheduler.sv
// tb_pick_job_scheduler: directed steps with random job words and sequencer timing,
// checked against a queue model and cycle budgets derived from the scheduling rules.
module tb_pick_job_scheduler;
    localparam int DEPTH = 4, ACK_MAX = 20, DONE_MAX = 40, GAP = 16;

    logic                   sys_clk = 1'b0, sys_rst = 1'b1;
    logic                   key_valid = 1'b0, cam_valid = 1'b0, sched_en = 1'b0, flush = 1'b0;
    logic                   job_finish = 1'b1;
    logic [34:0]            key_job = '0, cam_job = '0;
    logic                   job_start, busy, req_drop, ack_timeout, done_timeout;
    logic [34:0]            job_data;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0]             jobs_done;

    int          cyc = 0, compared = 0, mismatched = 0;
    int          drops = 0, acks = 0, m_drops = 0, m_done = 0;
    logic [34:0] exp_q [$];
    logic [34:0] held = '0;
    logic        held_ok = 1'b0, prev_start = 1'b0;

    pick_job_scheduler #(.DEPTH(DEPTH), .ACK_MAX(ACK_MAX), .DONE_MAX(DONE_MAX)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_valid(key_valid), .key_job(key_job),
        .cam_valid(cam_valid), .cam_job(cam_job), .sched_en(sched_en), .flush(flush),
        .job_start(job_start), .job_data(job_data), .job_finish(job_finish), .busy(busy),
        .fifo_count(fifo_count), .req_drop(req_drop), .ack_timeout(ack_timeout),
        .done_timeout(done_timeout), .jobs_done(jobs_done)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pulse tally plus job_data stability while the job is in flight
    always @(negedge sys_clk) begin
        if (req_drop) drops++;
        if (ack_timeout) acks++;
        if (job_start) check("start_one_cycle", prev_start, 0);
        prev_start = job_start;
        if (sys_rst) held_ok = 1'b0;
        else if (job_start) begin
            held = job_data;
            held_ok = 1'b1;
        end else if (!busy) held_ok = 1'b0;
        else if (held_ok) check("job_data_stable", job_data, held);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    function automatic logic [34:0] rjob();
        logic [63:0] r = {$urandom(), $urandom()};
        return r[34:0];
    endfunction

    task automatic enq(input bit use_key, input logic [34:0] w, output int e);
        if (use_key) begin key_valid = 1'b1; key_job = w; end
        else begin cam_valid = 1'b1; cam_job = w; end
        tick();
        e = cyc;
        key_valid = 1'b0;
        cam_valid = 1'b0;
    endtask

    task automatic wait_start(output int s);
        s = -1;
        for (int i = 0; i < 80 && s < 0; i++) begin
            tick();
            if (job_start) s = cyc;
        end
        check("job_start_seen", s >= 0, 1);
    endtask

    task automatic wait_idle(input int f);
        for (int i = 0; i < 40 && busy; i++) tick();
        check("gap_cycles", cyc - f, GAP);
    endtask

    // plays the sequencer for a job whose job_start has just been seen
    task automatic serve(input logic [34:0] w, output int f);
        check("job_data", job_data, w);
        tick($urandom_range(0, 4));
        job_finish = 1'b0;
        tick($urandom_range(1, 30));
        job_finish = 1'b1;
        tick();
        f = cyc;
        m_done++;
        check("jobs_done", jobs_done, m_done[7:0]);
        wait_idle(f);
    endtask

    initial begin
        int e, s, f, n;
        logic [34:0] w, w2, kw;
        tick(3);
        check("rst_job_start", job_start, 0);
        check("rst_job_data", job_data, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_req_drop", req_drop, 0);
        check("rst_ack_timeout", ack_timeout, 0);
        check("rst_done_timeout", done_timeout, 0);
        check("rst_jobs_done", jobs_done, 0);
        sys_rst = 1'b0;
        tick(2);

        // single manual job: x=132 y=80 wh=1 bias=0
        sched_en = 1'b1;
        w = {12'd0, 6'd1, 8'd80, 9'd132};
        enq(1'b1, w, e);
        wait_start(s);
        check("dispatch_latency", s, e + 2);
        check("job_data", job_data, w);
        tick(2);
        job_finish = 1'b0;
        tick(100);
        job_finish = 1'b1;
        tick();
        f = cyc;
        m_done++;
        check("jobs_done_first", jobs_done, 1);
        wait_idle(f);

        // simultaneous key and camera: key wins, camera dropped
        sched_en = 1'b0;
        kw = rjob();
        key_job = kw;
        cam_job = rjob();
        key_valid = 1'b1;
        cam_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        cam_valid = 1'b0;
        check("both_fifo_count", fifo_count, 1);
        tick();
        m_drops++;
        check("both_drops", drops, m_drops);
        sched_en = 1'b1;
        wait_start(s);
        serve(kw, f);

        // flush, alone and against a same-cycle request
        sched_en = 1'b0;
        enq($urandom_range(0, 1) == 1, rjob(), e);
        enq($urandom_range(0, 1) == 1, rjob(), e);
        check("pre_flush_count", fifo_count, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", fifo_count, 0);
        flush = 1'b1;
        key_valid = 1'b1;
        key_job = rjob();
        tick();
        flush = 1'b0;
        key_valid = 1'b0;
        check("flush_enq_count", fifo_count, 0);
        tick();
        m_drops++;
        check("flush_enq_drops", drops, m_drops);

        // five camera jobs into a four-deep queue, then full pop+push, FIFO order
        for (int i = 0; i < 5; i++) begin
            w = rjob();
            enq(1'b0, w, e);
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else m_drops++;
            check("fill_count", fifo_count, exp_q.size());
            tick($urandom_range(0, 2));
        end
        w = rjob();
        sched_en = 1'b1;
        key_valid = 1'b1;
        key_job = w;
        tick();
        e = cyc;
        key_valid = 1'b0;
        exp_q.push_back(w);
        check("full_pop_push_count", fifo_count, DEPTH);
        wait_start(s);
        check("pop_to_start", s, e + 1);
        serve(exp_q.pop_front(), f);
        while (exp_q.size() > 0) begin
            wait_start(s);
            check("back_to_back_start", s, f + GAP + 2);
            serve(exp_q.pop_front(), f);
        end
        check("fill_drops", drops, m_drops);
        check("drained_count", fifo_count, 0);

        // acknowledge timeout; sched_en dropping mid-job does not abort it
        sched_en = 1'b0;
        w = rjob();
        w2 = rjob();
        enq(1'b0, w, e);
        enq(1'b1, w2, e);
        sched_en = 1'b1;
        wait_start(s);
        check("ack_job_data", job_data, w);
        sched_en = 1'b0;
        for (int i = 0; i < ACK_MAX + 5 && !ack_timeout; i++) tick();
        check("ack_cycle", cyc, s + ACK_MAX);
        sched_en = 1'b1;
        wait_start(e);
        check("after_ack_start", e, s + ACK_MAX + GAP + 2);
        check("ack_jobs_done", jobs_done, m_done[7:0]);
        serve(w2, f);
        check("ack_pulses", acks, 1);

        // completion timeout is sticky until the next job_start
        w = rjob();
        enq($urandom_range(0, 1) == 1, w, e);
        wait_start(s);
        check("dispatch_latency2", s, e + 2);
        job_finish = 1'b0;
        tick(DONE_MAX);
        check("done_to_before", done_timeout, 0);
        tick();
        check("done_to_set", done_timeout, 1);
        tick(10);
        check("done_to_held", done_timeout, 1);
        check("done_to_busy", busy, 1);
        job_finish = 1'b1;
        tick();
        f = cyc;
        m_done++;
        check("done_to_jobs_done", jobs_done, m_done[7:0]);
        check("done_to_sticky", done_timeout, 1);
        wait_idle(f);
        w = rjob();
        enq(1'b0, w, e);
        wait_start(s);
        check("done_to_cleared", done_timeout, 0);
        serve(w, f);

        // reset during WAIT_DONE with two jobs still queued
        sched_en = 1'b0;
        for (int i = 0; i < 3; i++) enq(1'b1, rjob(), e);
        sched_en = 1'b1;
        wait_start(s);
        job_finish = 1'b0;
        tick(5);
        check("pre_rst_count", fifo_count, 2);
        #2 sys_rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_jobs_done", jobs_done, 0);
        tick();
        check("rst_count_after", fifo_count, 0);
        check("rst_data_after", job_data, 0);
        check("rst_start_after", job_start, 0);
        job_finish = 1'b1;
        sys_rst = 1'b0;
        m_done = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (job_start || busy) n++;
        end
        check("post_rst_quiet", n, 0);
        w = rjob();
        enq(1'b1, w, e);
        wait_start(s);
        check("post_rst_latency", s, e + 2);
        serve(w, f);
        check("final_drops", drops, m_drops);
        check("final_acks", acks, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
